// File: rtl/player_motion_if.sv
// Bundle of the per-frame control inputs and registered sprite outputs of player_motion.
`default_nettype none

interface player_motion_if;
  logic       frame_tick;
  logic       left;
  logic       right;
  logic       jump;
  logic [9:0] PlayerX;
  logic [9:0] PlayerY;
  logic       moving;
  logic       playerDirection;
  logic       airborne;

  modport master (
    output frame_tick, left, right, jump,
    input  PlayerX, PlayerY, moving, playerDirection, airborne
  );

  modport slave (
    input  frame_tick, left, right, jump,
    output PlayerX, PlayerY, moving, playerDirection, airborne
  );
endinterface

`default_nettype wire

// File: rtl/player_motion.sv
// Player sprite motion: horizontal run with edge saturation and a gravity jump arc,
// advancing once per frame_tick.
`default_nettype none

module player_motion #(
  parameter logic        [9:0] START_X  = 10'd64,
  parameter logic        [9:0] GROUND_Y = 10'd340,
  parameter logic        [9:0] X_MAX    = 10'd591,
  parameter logic        [9:0] SPEED_X  = 10'd2,
  parameter logic signed [5:0] JUMP_VEL = -6'sd12,
  parameter logic signed [5:0] GRAVITY  = 6'sd1,
  parameter logic signed [5:0] MAX_FALL = 6'sd8
) (
  input  logic            frame_Clk,
  input  logic            Reset,
  player_motion_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    AIR  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic        [9:0]  x_q, x_d;
  logic        [9:0]  y_q, y_d;
  logic signed [5:0]  vy_q, vy_d;
  logic               moving_q, moving_d;
  logic               dir_q, dir_d;
  logic               air_q, air_d;
  logic               jprev_q, jprev_d;

  logic               w_left_int, w_right_int, w_intent, w_press;
  logic        [10:0] w_x_sum;
  logic signed [10:0] w_y_air, w_y_launch, w_ground;
  logic signed [6:0]  w_vy_inc, w_vy_max;

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      x_q      <= START_X;
      y_q      <= GROUND_Y;
      vy_q     <= '0;
      moving_q <= 1'b0;
      dir_q    <= 1'b0;
      air_q    <= 1'b0;
      // Treat jump as already held so a button pressed through reset must be released first.
      jprev_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
      moving_q <= moving_d;
      dir_q    <= dir_d;
      air_q    <= air_d;
      jprev_q  <= jprev_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vy_d     = vy_q;
    moving_d = moving_q;
    dir_d    = dir_q;
    air_d    = air_q;
    jprev_d  = jprev_q;

    w_left_int  = bus.left & ~bus.right;
    w_right_int = bus.right & ~bus.left;
    w_intent    = w_left_int | w_right_int;
    w_press     = bus.jump & ~jprev_q;

    // Vertical arithmetic is done on 11-bit signed operands so overshoot above row 0 is visible.
    w_x_sum    = {1'b0, x_q} + {1'b0, SPEED_X};
    w_y_air    = {1'b0, y_q} + {{5{vy_q[5]}}, vy_q};
    w_y_launch = {1'b0, y_q} + {{5{JUMP_VEL[5]}}, JUMP_VEL};
    w_ground   = {1'b0, GROUND_Y};
    w_vy_inc   = {vy_q[5], vy_q} + {GRAVITY[5], GRAVITY};
    w_vy_max   = {MAX_FALL[5], MAX_FALL};

    if (bus.frame_tick) begin
      jprev_d  = bus.jump;
      moving_d = w_intent;

      if (w_left_int) begin
        dir_d = 1'b1;
        x_d   = (x_q < SPEED_X) ? 10'd0 : x_q - SPEED_X;
      end else if (w_right_int) begin
        dir_d = 1'b0;
        x_d   = (w_x_sum > {1'b0, X_MAX}) ? X_MAX : w_x_sum[9:0];
      end

      case (state_q)
        IDLE, RUN: begin
          if (w_press) begin
            state_d = AIR;
            y_d     = w_y_launch[10] ? 10'd0 : w_y_launch[9:0];
            vy_d    = JUMP_VEL + GRAVITY;
          end else begin
            state_d = w_intent ? RUN : IDLE;
            y_d     = GROUND_Y;
            vy_d    = '0;
          end
        end
        AIR: begin
          if (w_y_air >= w_ground) begin
            state_d = w_intent ? RUN : IDLE;
            y_d     = GROUND_Y;
            vy_d    = '0;
          end else if (w_y_air[10]) begin
            y_d  = 10'd0;
            vy_d = '0;
          end else begin
            y_d  = w_y_air[9:0];
            vy_d = (w_vy_inc > w_vy_max) ? MAX_FALL : w_vy_inc[5:0];
          end
        end
        default: begin
          state_d = IDLE;
          y_d     = GROUND_Y;
          vy_d    = '0;
        end
      endcase

      air_d = (state_d == AIR);
    end
  end

  assign bus.PlayerX         = x_q;
  assign bus.PlayerY         = y_q;
  assign bus.moving          = moving_q;
  assign bus.playerDirection = dir_q;
  assign bus.airborne        = air_q;

endmodule

`default_nettype wire

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: vector table plus jump, reset and edge sequences.
`default_nettype none

module tb_player_motion;

  logic frame_Clk = 1'b0;
  logic Reset     = 1'b0;
  int   errors    = 0;
  int   checks    = 0;

  player_motion_if bus ();

  player_motion dut (
    .frame_Clk (frame_Clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_Clk = ~frame_Clk;

  typedef struct {
    logic rst, tick, l, r, j;
    int   x, y;
    logic mv, dir, air;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int x, input int y,
                         input logic mv, input logic dir, input logic air);
    chk({tag, ".X"},   int'(bus.PlayerX), x);
    chk({tag, ".Y"},   int'(bus.PlayerY), y);
    chk({tag, ".mv"},  int'(bus.moving), int'(mv));
    chk({tag, ".dir"}, int'(bus.playerDirection), int'(dir));
    chk({tag, ".air"}, int'(bus.airborne), int'(air));
  endtask

  // Drive for one clock edge, then sample 1 time unit after it.
  task automatic step(input logic rst, input logic tick, input logic l,
                      input logic r, input logic j);
    Reset          = rst;
    bus.frame_tick = tick;
    bus.left       = l;
    bus.right      = r;
    bus.jump       = j;
    @(posedge frame_Clk);
    #1;
    Reset          = 1'b0;
    bus.frame_tick = 1'b0;
  endtask

  int jump_y[27] = '{328, 317, 307, 298, 290, 283, 277, 272, 268, 265, 263, 262, 262,
                     263, 265, 268, 272, 277, 283, 290, 298, 306, 314, 322, 330, 338, 340};

  initial begin
    bus.frame_tick = 1'b0;
    bus.left = 1'b0;
    bus.right = 1'b0;
    bus.jump = 1'b0;
    @(negedge frame_Clk);

    //            rst   tick  l     r     j      x    y    mv    dir   air
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  64, 340, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  66, 340, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  68, 340, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  70, 340, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,  68, 340, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  68, 340, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  68, 340, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  68, 340, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  70, 340, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,  70, 328, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1,  72, 317, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  64, 340, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].tick, vecs[i].l, vecs[i].r, vecs[i].j);
      chk_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y,
              vecs[i].mv, vecs[i].dir, vecs[i].air);
    end

    // Full jump arc with jump held, then held past landing.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 27; t++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk($sformatf("arc%0d.Y", t + 1), int'(bus.PlayerY), jump_y[t]);
      chk($sformatf("arc%0d.air", t + 1), int'(bus.airborne), (t == 26) ? 0 : 1);
    end
    for (int t = 0; t < 3; t++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk_all($sformatf("held%0d", t), 64, 340, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("release", 64, 340, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_all("relaunch", 64, 328, 1'b0, 1'b0, 1'b1);

    // Reset landing mid-jump at tick 5, after drifting right.
    for (int t = 0; t < 4; t++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk_all("jump5", 72, 290, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk_all("midreset", 64, 340, 1'b0, 1'b0, 1'b0);

    // Jump held through reset must not launch until released.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_all("heldrst", 64, 340, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_all("pressrst", 64, 328, 1'b0, 1'b0, 1'b1);

    // Left edge saturation.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 31; t++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("x2", 2, 340, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("xl0a", 0, 340, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("xl0b", 0, 340, 1'b1, 1'b1, 1'b0);

    // Right edge saturation.
    for (int t = 0; t < 295; t++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("x590", 590, 340, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("xr591a", 591, 340, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("xr591b", 591, 340, 1'b1, 1'b0, 1'b0);

    // No tick for 100 cycles while buttons toggle: everything holds.
    for (int t = 0; t < 100; t++)
      step(1'b0, 1'b0, t[0], t[1], t[2]);
    chk_all("stall", 591, 340, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/player_motion.md
PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 SHALL have parameter START_X, default 10'd64, reset X position of the player sprite's top-left corner.
REQ-002 SHALL have parameter GROUND_Y, default 10'd340, floor Y position of the sprite's top-left corner.
REQ-003 SHALL have parameter X_MAX, default 10'd591, largest legal PlayerX (640 - 48 - 1).
REQ-004 SHALL have parameter SPEED_X, default 10'd2, pixels moved per frame tick.
REQ-005 SHALL have parameter JUMP_VEL, default -6'sd12, signed launch velocity in pixels per tick.
REQ-006 SHALL have parameter GRAVITY, default 6'sd1, velocity increment per airborne tick.
REQ-007 SHALL have parameter MAX_FALL, default 6'sd8, terminal downward velocity.
REQ-008 SHALL have port frame_Clk, input, 1 bit, the single clock.
REQ-009 SHALL have port Reset, input, 1 bit, synchronous, active-high.
REQ-010 SHALL have port frame_tick, input, 1 bit, one-cycle pulse per video frame; the only update strobe.
REQ-011 SHALL have ports left, right and jump, input, 1 bit each, debounced button levels.
REQ-012 SHALL have ports PlayerX and PlayerY, output, 10 bits each, registered sprite top-left position.
REQ-013 SHALL have port moving, output, 1 bit, registered horizontal-intent flag.
REQ-014 SHALL have port playerDirection, output, 1 bit, registered facing (0 = right, 1 = left).
REQ-015 SHALL have port airborne, output, 1 bit, registered, high in state AIR.

Function
REQ-016 SHALL change all state and outputs only on frame_Clk edges where frame_tick=1; new values are visible the cycle after the tick.
REQ-017 SHALL implement FSM states IDLE, RUN and AIR, plus signed 6-bit register vy and 1-bit register jump_prev.
REQ-018 SHALL define horizontal intent: exactly one of left/right high; both high or both low means no intent.
REQ-019 SHALL set moving=1 on intent at the tick, else 0, independent of clamping and state.
REQ-020 SHALL set playerDirection=1 on left intent and 0 on right intent, and hold it on no intent.
REQ-021 SHALL apply X motion on intent in every state: PlayerX ± SPEED_X, saturating to [0, X_MAX] with no wrap-around.
REQ-022 SHALL detect a jump press as jump=1 && jump_prev=0 at a tick; jump_prev samples jump on every tick.
REQ-023 SHALL, from IDLE or RUN with no press, go to RUN on intent and to IDLE otherwise; PlayerY stays GROUND_Y and vy stays 0.
REQ-024 SHALL, on a jump press in IDLE or RUN, enter AIR with PlayerY_next = PlayerY + JUMP_VEL and vy_next = JUMP_VEL + GRAVITY.
REQ-025 SHALL, in AIR, set PlayerY_next = PlayerY + vy and vy_next = min(vy + GRAVITY, MAX_FALL), using signed arithmetic on 11-bit extended operands.
REQ-026 SHALL land in AIR when PlayerY + vy >= GROUND_Y: PlayerY = GROUND_Y, vy = 0, next state RUN on intent else IDLE.
REQ-027 SHALL clamp in AIR when PlayerY + vy < 0: PlayerY = 0 and vy = 0, remaining in AIR.
REQ-028 SHALL ignore jump presses in AIR (no double jump), while jump_prev still updates.
REQ-029 SHALL set airborne = (next state == AIR), registered with the state.

Reset
REQ-030 SHALL, with Reset=1 at a clock edge regardless of frame_tick, load PlayerX=START_X, PlayerY=GROUND_Y, vy=0, state IDLE, moving=0, playerDirection=0, airborne=0, jump_prev=1.
REQ-031 SHALL give Reset priority over frame_tick; reset mid-jump returns to the floor immediately.
REQ-032 SHALL require a jump held through reset to be released before it can trigger a jump.

Verification
REQ-033 Reset, then 3 ticks with right=1 -> PlayerX 66, 68, 70; moving=1; playerDirection=0; PlayerY=340.
REQ-034 From X=2, 2 ticks with left=1 -> PlayerX 0, 0; playerDirection=1. From X=590 with right=1 -> 591.
REQ-035 Jump press at tick 1 from Y=340 -> Y 328, 317, ..., apex 262 at ticks 12-13, 298 at tick 21, 338 at tick 26, 340 at tick 27 with airborne=0.
REQ-036 Jump held continuously across the landing -> no relaunch until jump is released for at least one tick.
REQ-037 Reset asserted at tick 5 of a jump -> next cycle Y=340, X=64, airborne=0, state IDLE.
REQ-038 left=right=1 for 4 ticks -> X unchanged, moving=0, direction held; frame_tick=0 for 100 cycles -> all outputs stable.
